serial_eight_bit_adder: RTL and testbench

SERIAL_EIGHT_BIT_ADDER -- requirements
Module: serial_eight_bit_adder

---
 rtl/serial_eight_bit_adder_pkg.sv | 13 +
 rtl/serial_eight_bit_adder_if.sv | 35 +++
 rtl/serial_eight_bit_adder_full_adder.sv | 13 +
 rtl/serial_eight_bit_adder.sv | 126 ++++++++++++
 tb/tb_serial_eight_bit_adder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_eight_bit_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// The optional OVERFLOW output is controlled by macro SERIAL_ADDER_OVERFLOW_EN.
package serial_eight_bit_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_eight_bit_adder_if.sv
// Request/result bundle between a requester and the serial adder.
// OVERFLOW exists only when SERIAL_ADDER_OVERFLOW_EN is defined.
interface serial_eight_bit_adder_if
    import serial_eight_bit_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] SUM;
    logic             CARRY;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             OVERFLOW;
`endif

    modport master (
        output start, A, B,
        input  busy, done, SUM, CARRY
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , input OVERFLOW
`endif
    );

    modport slave (
        input  start, A, B,
        output busy, done, SUM, CARRY
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , output OVERFLOW
`endif
    );

endinterface

// File: rtl/serial_eight_bit_adder_full_adder.sv
// Single-bit full adder used by the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_eight_bit_adder.sv
// Bit-serial adder: one bit pair per cycle LSB-first, result published on DONE.
// Define SERIAL_ADDER_OVERFLOW_EN to add the signed OVERFLOW output.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// SHIFT | one bit added per cycle; last cycle (cnt == WIDTH) only advances
// DONE  | result visible, done pulse, back to IDLE
module serial_eight_bit_adder
    import serial_eight_bit_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  logic                    clk,
    input  logic                    rst_n,
    serial_eight_bit_adder_if.slave bus
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
    localparam logic [CW-1:0] MSB_CNT  = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, carry_out_q;
    logic             fa_s, fa_cout;
    logic             accept, shift_en, load_out;
    logic             busy_c, done_c;

    full_adder u_full_adder (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign accept   = (state_q == IDLE) && bus.start;
    assign shift_en = (state_q == SHIFT) && (cnt_q != LAST_CNT);
    assign load_out = (state_q == SHIFT) && (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state_q)
            SHIFT:   busy_c = 1'b1;
            DONE: begin
                busy_c = 1'b1;
                done_c = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= bus.A;
                b_q     <= bus.B;
                res_q   <= '0;
                cnt_q   <= '0;
                carry_q <= 1'b0;
            end else if (shift_en) begin
                a_q     <= a_q >> 1;
                b_q     <= b_q >> 1;
                res_q   <= {fa_s, res_q[WIDTH-1:1]};
                cnt_q   <= cnt_q + CW'(1);
                carry_q <= fa_cout;
            end
            if (load_out) begin
                sum_q       <= res_q;
                carry_out_q <= carry_q;
            end
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    // Carry entering the MSB is only visible during the MSB shift, so keep it.
    logic msb_cin_q, ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_cin_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (accept)
                msb_cin_q <= 1'b0;
            else if (shift_en && (cnt_q == MSB_CNT))
                msb_cin_q <= carry_q;
            if (load_out)
                ovf_q <= msb_cin_q ^ carry_q;
        end
    end

    assign bus.OVERFLOW = ovf_q;
`endif

    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign bus.SUM   = sum_q;
    assign bus.CARRY = carry_out_q;

endmodule

// File: tb/tb_serial_eight_bit_adder.sv
// Directed bench for serial_eight_bit_adder: vector table plus corner-case sequences.
// OVERFLOW checks are compiled in with SERIAL_ADDER_OVERFLOW_EN.
module tb_serial_eight_bit_adder;
    import serial_eight_bit_adder_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_eight_bit_adder_if #(.WIDTH(W)) bus ();

    serial_eight_bit_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } vec_t;

    vec_t vecs [8];

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] prev_sum;
    logic       prev_carry;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Launch one addition, scramble operands after acceptance, watch for done.
    task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic [7:0] esum,
                           input logic ecarry, input logic eovf, input string tag);
        int lat;
        bit mid_ok;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A = ~a;
        bus.B = ~b;
        lat = 0;
        mid_ok = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = c;
                break;
            end
            if (!bus.busy || bus.SUM !== prev_sum || bus.CARRY !== prev_carry) mid_ok = 1'b0;
        end
        check({tag, " latency"}, lat, 10);
        check({tag, " sum"}, {24'd0, bus.SUM}, {24'd0, esum});
        check({tag, " carry"}, {31'd0, bus.CARRY}, {31'd0, ecarry});
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check({tag, " overflow"}, {31'd0, bus.OVERFLOW}, {31'd0, eovf});
`else
        if (eovf === 1'bx) $display("note: %s overflow expectation undefined", tag);
`endif
        check({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd1);
        check({tag, " held_mid_op"}, {31'd0, mid_ok}, 32'd1);
        @(negedge clk);
        check({tag, " done_one_cycle"}, {31'd0, bus.done}, 32'd0);
        check({tag, " idle_after"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " sum_held"}, {24'd0, bus.SUM}, {24'd0, esum});
        prev_sum   = esum;
        prev_carry = ecarry;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ndone;
        int  npulse;
        int  times [4];
        bit  sum_ok;
        bit  drop;
        logic [7:0] got_sum;

        vecs[0] = '{8'h14, 8'h06, 8'h1A, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'hC0, 8'hC0, 8'h80, 1'b1, 1'b0};
        vecs[6] = '{8'h40, 8'h40, 8'h80, 1'b0, 1'b1};
        vecs[7] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset sum", {24'd0, bus.SUM}, 32'd0);
        check("reset carry", {31'd0, bus.CARRY}, 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check("reset overflow", {31'd0, bus.OVERFLOW}, 32'd0);
`endif
        rst_n = 1'b1;
        prev_sum = 8'h00;
        prev_carry = 1'b0;

        for (int i = 0; i < 8; i++)
            run_add(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].carry, vecs[i].ovf,
                    $sformatf("vec%0d", i));

        // Restart attempts during SHIFT and during DONE must both be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 8'h28;
        bus.B = 8'h20;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        got_sum = 8'h00;
        drop = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (drop) begin
                bus.start = 1'b0;
                drop = 1'b0;
            end
            if (c == 3) begin
                bus.start = 1'b1;
                bus.A = 8'h01;
                bus.B = 8'h01;
            end else if (c == 4) begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                ndone++;
                got_sum = bus.SUM;
                bus.start = 1'b1;
                drop = 1'b1;
            end
        end
        bus.start = 1'b0;
        check("restart done_count", ndone, 1);
        check("restart sum", {24'd0, got_sum}, 32'h48);
        check("restart idle_end", {31'd0, bus.busy}, 32'd0);
        check("restart sum_held", {24'd0, bus.SUM}, 32'h48);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 8'h10;
        bus.B = 8'h10;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort sum", {24'd0, bus.SUM}, 32'd0);
        check("abort carry", {31'd0, bus.CARRY}, 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check("abort overflow", {31'd0, bus.OVERFLOW}, 32'd0);
`endif
        ndone = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("abort no_done", ndone, 0);
        prev_sum = 8'h00;
        prev_carry = 1'b0;
        run_add(8'h03, 8'h04, 8'h07, 1'b0, 1'b0, "post_reset");

        // start held high: back-to-back additions.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 8'h05;
        bus.B = 8'h0A;
        npulse = 0;
        sum_ok = 1'b1;
        for (int i = 0; i < 4; i++) times[i] = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (npulse < 4) times[npulse] = c;
                npulse++;
                if (bus.SUM !== 8'h0F) sum_ok = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("held pulse_count", npulse, 4);
        check("held first_latency", times[0], 10);
        check("held period_1", times[1] - times[0], 11);
        check("held period_2", times[2] - times[1], 11);
        check("held sums", {31'd0, sum_ok}, 32'd1);
        repeat (15) @(negedge clk);
        check("held drained", {31'd0, bus.busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
